// File: rtl/vend_txn_controller.sv
// Vending transaction sequencer: coin credit, selection checks, dispense and change handshakes.
// Optional idle auto-refund is enabled by defining VEND_TIMEOUT_EN.
module vend_txn_controller #(
  parameter int unsigned PRICE_A     = 5,
  parameter int unsigned PRICE_B     = 10,
  parameter int unsigned PRICE_C     = 20,
  parameter int unsigned CREDIT_W    = 6,
  parameter int unsigned MAX_CREDIT  = 40,
  parameter int unsigned STOCK_W     = 4,
  parameter int unsigned STOCK_INIT  = 8,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          coin,
  input  logic                sel_vld,
  input  logic [1:0]          sel_id,
  input  logic                cancel,
  input  logic                stock_load,
  input  logic [1:0]          stock_id,
  input  logic [STOCK_W-1:0]  stock_cnt,
  output logic                disp_req,
  output logic [1:0]          disp_id,
  input  logic                disp_ack,
  output logic                chg_req,
  input  logic                chg_ack,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic                coin_rej,
  output logic                err_funds,
  output logic                err_stock
);

  typedef enum logic [1:0] {StCollect, StDispense, StChange} state_e;

  state_e              state_q;
  logic [CREDIT_W-1:0] credit_q;
  logic                disp_req_q, chg_req_q, busy_q;
  logic [1:0]          disp_id_q;
  logic                coin_rej_q, err_funds_q, err_stock_q;
  logic [STOCK_W-1:0]  stock_q [3];

  logic [CREDIT_W:0]   coin_val, credit_sum;
  logic                coin_fits;
  logic [CREDIT_W-1:0] sel_price, disp_price, credit_left;
  logic [STOCK_W-1:0]  sel_stock;
  logic                disp_done;
  logic                timeout_hit;

  function automatic logic [CREDIT_W-1:0] price_of(input logic [1:0] id);
    case (id)
      2'd0:    return CREDIT_W'(PRICE_A);
      2'd1:    return CREDIT_W'(PRICE_B);
      2'd2:    return CREDIT_W'(PRICE_C);
      default: return '0;
    endcase
  endfunction

  always_comb begin
    case (coin)
      2'd1:    coin_val = (CREDIT_W+1)'(5);
      2'd2:    coin_val = (CREDIT_W+1)'(10);
      2'd3:    coin_val = (CREDIT_W+1)'(20);
      default: coin_val = '0;
    endcase
    credit_sum  = {1'b0, credit_q} + coin_val;
    coin_fits   = credit_sum <= (CREDIT_W+1)'(MAX_CREDIT);
    sel_price   = price_of(sel_id);
    disp_price  = price_of(disp_id_q);
    credit_left = credit_q - disp_price;
    case (sel_id)
      2'd0:    sel_stock = stock_q[0];
      2'd1:    sel_stock = stock_q[1];
      2'd2:    sel_stock = stock_q[2];
      default: sel_stock = '0;
    endcase
  end

  assign disp_done = (state_q == StDispense) && disp_req_q && disp_ack;

`ifdef VEND_TIMEOUT_EN
  localparam int unsigned TmoW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [TmoW-1:0] idle_q;
  logic            idle_cyc;

  assign idle_cyc    = (state_q == StCollect) && (credit_q != '0) && (coin == 2'b00) &&
                       !sel_vld && !cancel;
  assign timeout_hit = idle_cyc && (idle_q == TmoW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst || !idle_cyc || timeout_hit) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_q + TmoW'(1);
    end
  end
`else
  logic unused_timeout;
  assign timeout_hit    = 1'b0;
  assign unused_timeout = (TIMEOUT_CYC != 0);
`endif

  // A load on the same cycle as a dispense decrement to the same id overrides the decrement.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        stock_q[i] <= STOCK_W'(STOCK_INIT);
      end else if (stock_load && (stock_id == 2'(i))) begin
        stock_q[i] <= stock_cnt;
      end else if (disp_done && (disp_id_q == 2'(i)) && (stock_q[i] != '0)) begin
        stock_q[i] <= stock_q[i] - STOCK_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StCollect;
      credit_q    <= '0;
      disp_req_q  <= 1'b0;
      disp_id_q   <= 2'd0;
      chg_req_q   <= 1'b0;
      busy_q      <= 1'b0;
      coin_rej_q  <= 1'b0;
      err_funds_q <= 1'b0;
      err_stock_q <= 1'b0;
    end else begin
      coin_rej_q  <= 1'b0;
      err_funds_q <= 1'b0;
      err_stock_q <= 1'b0;
      unique case (state_q)
        StCollect: begin
          // A coin owns its cycle; any cancel or selection alongside it is dropped.
          if (coin != 2'b00) begin
            if (coin_fits) begin
              credit_q <= credit_sum[CREDIT_W-1:0];
            end else begin
              coin_rej_q <= 1'b1;
            end
          end else if (cancel || timeout_hit) begin
            if (credit_q != '0) begin
              state_q   <= StChange;
              chg_req_q <= 1'b1;
              busy_q    <= 1'b1;
            end
          end else if (sel_vld) begin
            if ((sel_id == 2'd3) || (sel_stock == '0)) begin
              err_stock_q <= 1'b1;
            end else if (credit_q < sel_price) begin
              err_funds_q <= 1'b1;
            end else begin
              state_q    <= StDispense;
              disp_req_q <= 1'b1;
              disp_id_q  <= sel_id;
              busy_q     <= 1'b1;
            end
          end
        end
        StDispense: begin
          coin_rej_q <= (coin != 2'b00);
          if (disp_done) begin
            credit_q   <= credit_left;
            disp_req_q <= 1'b0;
            if (credit_left != '0) begin
              state_q   <= StChange;
              chg_req_q <= 1'b1;
            end else begin
              state_q <= StCollect;
              busy_q  <= 1'b0;
            end
          end
        end
        StChange: begin
          coin_rej_q <= (coin != 2'b00);
          if (chg_req_q && chg_ack) begin
            chg_req_q <= 1'b0;
            if (credit_q > CREDIT_W'(5)) begin
              credit_q <= credit_q - CREDIT_W'(5);
            end else begin
              credit_q <= '0;
              state_q  <= StCollect;
              busy_q   <= 1'b0;
            end
          end else if (!chg_req_q) begin
            chg_req_q <= 1'b1;
          end
        end
        default: state_q <= StCollect;
      endcase
    end
  end

  assign disp_req  = disp_req_q;
  assign disp_id   = disp_id_q;
  assign chg_req   = chg_req_q;
  assign credit    = credit_q;
  assign busy      = busy_q;
  assign coin_rej  = coin_rej_q;
  assign err_funds = err_funds_q;
  assign err_stock = err_stock_q;

endmodule
